// File: rtl/bit_stream_feeder.sv
// bit_stream_feeder: debounces load/step buttons and serialises a captured pattern MSB first on w, strobed by adv.
module bsf_button #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2, lvl, lvl_q;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      lvl <= 1'b0;
      lvl_q <= 1'b0;
      pulse <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      lvl_q <= lvl;
      pulse <= lvl & ~lvl_q;
      if (s2 == lvl) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        lvl <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

module bit_stream_feeder #(
  parameter int WIDTH = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_btn,
  input  logic                       step_btn,
  input  logic [WIDTH-1:0]           pattern,
  output logic                       w,
  output logic                       w_valid,
  output logic                       adv,
  output logic [$clog2(WIDTH+1)-1:0] remaining,
  output logic                       done
);
  localparam int RW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] shreg;
  logic load_pulse, step_pulse;
  bsf_button #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (.clk(clk), .reset(reset), .raw(load_btn), .pulse(load_pulse));
  bsf_button #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (.clk(clk), .reset(reset), .raw(step_btn), .pulse(step_pulse));
  assign w = (state == SHIFT) & shreg[WIDTH-1];
  assign w_valid = state == SHIFT;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      remaining <= '0;
      adv <= 1'b0;
    end else if (load_pulse) begin
      state <= SHIFT;
      shreg <= pattern;
      remaining <= RW'(WIDTH);
      adv <= 1'b0;
    end else if (state == SHIFT) begin
      // w stays put through the adv cycle; the shift lands at its end
      if (adv) begin
        adv <= 1'b0;
        shreg <= shreg << 1;
        remaining <= remaining - 1'b1;
        if (remaining == RW'(1)) state <= DONE;
      end else adv <= step_pulse;
    end
  end
endmodule

// File: tb/tb_bit_stream_feeder.sv
// tb_bit_stream_feeder: directed test of debounce, serialisation, reload, priority and reset abort.
module tb_bit_stream_feeder;
  logic clk = 0, reset = 1, load_btn = 0, step_btn = 0;
  logic [7:0] pattern = 8'h00;
  logic w, w_valid, adv, done;
  logic [3:0] remaining;
  int checks = 0, failures = 0, viol = 0;
  logic advq[$];
  logic prev_adv = 0;
  logic [7:0] exp_bits;

  bit_stream_feeder #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .load_btn(load_btn), .step_btn(step_btn), .pattern(pattern),
    .w(w), .w_valid(w_valid), .adv(adv), .remaining(remaining), .done(done));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (adv) advq.push_back(w);
    if ((adv && !w_valid) || (adv && prev_adv)) viol++;
    prev_adv = adv;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_load();
    load_btn = 1; cycles(10); load_btn = 0; cycles(10);
  endtask

  task automatic press_step();
    step_btn = 1; cycles(10); step_btn = 0; cycles(10);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_w"}, 32'(w), 0);
    check({tag, "_wv"}, 32'(w_valid), 0);
    check({tag, "_adv"}, 32'(adv), 0);
    check({tag, "_rem"}, 32'(remaining), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  task automatic check_stream(input string tag, input logic [7:0] bits);
    check({tag, "_count"}, 32'(advq.size()), 8);
    for (int i = 0; i < 8; i++)
      if (i < advq.size()) check($sformatf("%s_bit%0d", tag, i), 32'(advq[i]), 32'(bits[7-i]));
  endtask

  initial begin
    int seen_at;
    int seen_n;
    // 1: reset and idle
    cycles(2);
    reset = 0;
    cycles(20);
    check_idle_outputs("idle");
    check("idle_advcount", 32'(advq.size()), 0);
    // 2: full stream of 0xCB
    pattern = 8'hCB;
    press_load();
    check("load_wv", 32'(w_valid), 1);
    check("load_rem", 32'(remaining), 8);
    check("load_w", 32'(w), 1);
    advq.delete();
    repeat (8) press_step();
    exp_bits = 8'hCB;
    check_stream("cb", exp_bits);
    check("cb_done", 32'(done), 1);
    check("cb_wv", 32'(w_valid), 0);
    check("cb_rem", 32'(remaining), 0);
    press_step();
    check("done_step_ignored", 32'(advq.size()), 8);
    // 3: bounce rejection then a clean hold
    press_load();
    advq.delete();
    for (int i = 0; i < 4; i++) begin
      step_btn = (i % 2 == 0); cycles(2);
    end
    step_btn = 0;
    cycles(10);
    check("bounce_noadv", 32'(advq.size()), 0);
    step_btn = 1;
    seen_at = -1;
    seen_n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (adv) begin seen_n++; seen_at = i; end
    end
    step_btn = 0;
    cycles(10);
    check("hold_one_adv", 32'(seen_n), 1);
    check("hold_latency", 32'(seen_at), 8);
    check("hold_w", 32'(advq.size() > 0 ? advq[0] : 1'bx), 1);
    check("hold_rem", 32'(remaining), 7);
    // 4: mid-stream reload after three advs
    press_step();
    press_step();
    check("mid_rem", 32'(remaining), 5);
    pattern = 8'h0F;
    press_load();
    check("reload_rem", 32'(remaining), 8);
    check("reload_w", 32'(w), 0);
    advq.delete();
    repeat (8) press_step();
    exp_bits = 8'h0F;
    check_stream("0f", exp_bits);
    check("0f_done", 32'(done), 1);
    // 5: simultaneous load and step in SHIFT
    pattern = 8'hCB;
    press_load();
    press_step();
    check("pre_sim_rem", 32'(remaining), 7);
    advq.delete();
    load_btn = 1; step_btn = 1;
    cycles(10);
    load_btn = 0; step_btn = 0;
    cycles(10);
    check("sim_noadv", 32'(advq.size()), 0);
    check("sim_rem", 32'(remaining), 8);
    check("sim_w", 32'(w), 1);
    // 6: reset mid-stream with step held
    repeat (3) press_step();
    check("prereset_rem", 32'(remaining), 5);
    step_btn = 1;
    cycles(2);
    reset = 1;
    cycles(1);
    check_idle_outputs("rst");
    reset = 0;
    advq.delete();
    cycles(12);
    step_btn = 0;
    cycles(10);
    check("rst_noadv", 32'(advq.size()), 0);
    check("rst_done", 32'(done), 0);
    check("rst_wv", 32'(w_valid), 0);
    check("adv_rules", 32'(viol), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
